// File: rtl/img_pkg.sv
// Shared pixel/window types and the window generator state encoding.
package img_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    // win[r][c]: r = 0 is the oldest (top) row, c = 0 the leftmost column
    typedef pix_t [2:0][2:0] win_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One-line pixel store: one write and one registered read per cycle, no reset on contents.
module line_buffer
    import img_pkg::*;
#(
    parameter  int DEPTH = 640,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  pix_t          wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output pix_t          rd_data_o
);

    pix_t mem_q [DEPTH];
    pix_t rd_data_q;

    // storage write and registered read (read returns the pre-write contents)
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/window_gen.sv
// Streams raster pixels into a 3x3 neighbourhood window (valid-only border) with frame tracking.
module window_gen
    import img_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sof,
    input  logic pix_valid,
    input  pix_t pix_in,
    output win_t win,
    output logic win_valid,
    output logic frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2'd2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2'd2);

    state_t        state_q;
    logic [CW-1:0] col_q, col_d, cur_col_s;
    logic [RW-1:0] row_q, row_d, cur_row_s;
    logic          restart_s, accept_s, is_last_s;
    win_t          win_q;
    logic          win_valid_q, frame_done_q;
    pix_t          lb_r1_rd_s, lb_r2_rd_s;

    // position of the pixel on the input and the position expected next
    always_comb begin
        restart_s = pix_valid && sof;
        accept_s  = restart_s || (pix_valid && (state_q != ST_IDLE));
        cur_col_s = restart_s ? {CW{1'b0}} : col_q;
        cur_row_s = restart_s ? {RW{1'b0}} : row_q;
        is_last_s = (cur_col_s == COL_LAST) && (cur_row_s == ROW_LAST);
        col_d     = col_q;
        row_d     = row_q;
        if (accept_s) begin
            if (cur_col_s == COL_LAST) begin
                col_d = {CW{1'b0}};
                row_d = (cur_row_s == ROW_LAST) ? {RW{1'b0}} : cur_row_s + RW'(1'b1);
            end else begin
                col_d = cur_col_s + CW'(1'b1);
                row_d = cur_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Reads run one column ahead (next expected col) so the registered read
    // data is ready in the cycle the pixel for that column is accepted.
    line_buffer #(.DEPTH(IMG_W)) u_lb_r1 (
        .clk       (clk),
        .we_i      (accept_s),
        .wr_addr_i (cur_col_s),
        .wr_data_i (pix_in),
        .rd_addr_i (col_d),
        .rd_data_o (lb_r1_rd_s)
    );

    line_buffer #(.DEPTH(IMG_W)) u_lb_r2 (
        .clk       (clk),
        .we_i      (accept_s),
        .wr_addr_i (cur_col_s),
        .wr_data_i (lb_r1_rd_s),
        .rd_addr_i (col_d),
        .rd_data_o (lb_r2_rd_s)
    );

    // frame state machine, position counters and registered window outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            win_q        <= {(9*PIX_W){1'b0}};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= accept_s && (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
            frame_done_q <= accept_s && is_last_s && (state_q == ST_STREAM);
            if (accept_s) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb_r2_rd_s;
                win_q[1][2] <= lb_r1_rd_s;
                win_q[2][2] <= pix_in;
            end
            case (state_q)
                ST_IDLE: begin
                    if (restart_s) state_q <= ST_FILL;
                end
                ST_FILL: begin
                    if (restart_s) state_q <= ST_FILL;
                    else if (accept_s && (cur_row_s == ROW_TWO) && (cur_col_s == COL_TWO))
                        state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (restart_s) state_q <= ST_FILL;
                    else if (accept_s && is_last_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign win        = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen: directed 4x4 frames plus randomized 13x7 frames against a frame-array model.
module tb_window_gen;
    import img_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sof = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_in = 8'd0;
    win_t       win_a, win_b, obs_win;
    logic       va, vb, da, db, obs_valid, obs_done;
    bit         sel = 1'b0;

    window_gen #(.IMG_W(4), .IMG_H(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .win(win_a), .win_valid(va), .frame_done(da)
    );

    window_gen #(.IMG_W(13), .IMG_H(7)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .win(win_b), .win_valid(vb), .frame_done(db)
    );

    assign obs_win   = sel ? win_b : win_a;
    assign obs_valid = sel ? vb : va;
    assign obs_done  = sel ? db : da;

    always #5 clk = ~clk;

    // reference model: the frame as a 2-D array, position counted from the last sof
    int         mw = 4, mh = 4, pos = 0;
    bit         in_frame = 1'b0, win_known = 1'b0;
    logic       exp_valid = 1'b0, exp_done = 1'b0;
    win_t       exp_win, first_win;
    logic [7:0] img [16][16];
    int         n_total = 0, n_pass = 0;

    task automatic step(input logic v, input logic s, input logic [7:0] p);
        int r, c;
        pix_valid = v; sof = s; pix_in = p;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (v && s) begin
            in_frame = 1'b1;
            pos = 0;
        end
        if (v && in_frame) begin
            r = pos / mw;
            c = pos % mw;
            img[r][c] = p;
            if (r >= 2 && c >= 2) begin
                exp_valid = 1'b1;
                win_known = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[i][j] = img[r-2+i][c-2+j];
            end else begin
                win_known = 1'b0;
            end
            if (pos == mw*mh - 1) begin
                exp_done = 1'b1;
                in_frame = 1'b0;
            end
            pos++;
        end
    endtask

    task automatic test_reset();
        exp_win = '0;
        rst_n = 1'b1; #3; rst_n = 1'b0; #1;
        n_total++; if ({obs_valid, obs_done} !== 2'b00) $display("FAIL reset_flags_a: got %b%b want 00", obs_valid, obs_done); else n_pass++;
        n_total++; if (obs_win !== exp_win) $display("FAIL reset_win_a: got %h want %h", obs_win, exp_win); else n_pass++;
        n_total++; if ({vb, db} !== 2'b00 || win_b !== exp_win) $display("FAIL reset_b: got %b%b %h want 00 %h", vb, db, win_b, exp_win); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({obs_valid, obs_done} !== 2'b00 || obs_win !== exp_win) $display("FAIL reset_hold: got %b%b %h", obs_valid, obs_done, obs_win); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        in_frame = 1'b0; win_known = 1'b1;
    endtask

    task automatic test_ramp();
        int nwin = 0, ndone = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 0, 8'(k));
            n_total++; if ({obs_valid, obs_done} !== {exp_valid, exp_done}) $display("FAIL ramp_flags k=%0d: got %b%b want %b%b", k, obs_valid, obs_done, exp_valid, exp_done); else n_pass++;
            if (win_known) begin
                n_total++; if (obs_win !== exp_win) $display("FAIL ramp_win k=%0d: got %h want %h", k, obs_win, exp_win); else n_pass++;
            end
            if (k == 10) begin
                n_total++; if (obs_valid !== 1'b1 || obs_win !== first_win) $display("FAIL ramp_first: got %b %h want 1 %h", obs_valid, obs_win, first_win); else n_pass++;
            end
            nwin += int'(obs_valid); ndone += int'(obs_done);
        end
        n_total++; if (nwin != 4 || ndone != 1) $display("FAIL ramp_count: got %0d windows %0d done want 4 1", nwin, ndone); else n_pass++;
    endtask

    task automatic test_gaps();
        int nwin = 0;
        logic v;
        for (int j = 0; j < 32; j++) begin
            v = (j % 2 == 0);
            step(v, v && (j == 0), v ? 8'(j/2) : 8'($urandom));
            n_total++; if ({obs_valid, obs_done} !== {exp_valid, exp_done}) $display("FAIL gaps_flags j=%0d: got %b%b want %b%b", j, obs_valid, obs_done, exp_valid, exp_done); else n_pass++;
            if (win_known) begin
                n_total++; if (obs_win !== exp_win) $display("FAIL gaps_win j=%0d: got %h want %h", j, obs_win, exp_win); else n_pass++;
            end
            nwin += int'(obs_valid);
        end
        n_total++; if (nwin != 4) $display("FAIL gaps_count: got %0d want 4", nwin); else n_pass++;
    endtask

    task automatic test_restart();
        int ndone = 0, k;
        for (int j = 0; j < 22; j++) begin
            k = (j < 6) ? j : j - 6;
            step(1'b1, (j == 0) || (j == 6), 8'(k));
            n_total++; if ({obs_valid, obs_done} !== {exp_valid, exp_done}) $display("FAIL restart_flags j=%0d: got %b%b want %b%b", j, obs_valid, obs_done, exp_valid, exp_done); else n_pass++;
            if (win_known) begin
                n_total++; if (obs_win !== exp_win) $display("FAIL restart_win j=%0d: got %h want %h", j, obs_win, exp_win); else n_pass++;
            end
            if (j == 16) begin
                n_total++; if (obs_valid !== 1'b1 || obs_win !== first_win) $display("FAIL restart_first: got %b %h want 1 %h", obs_valid, obs_win, first_win); else n_pass++;
            end
            ndone += int'(obs_done);
        end
        n_total++; if (ndone != 1) $display("FAIL restart_done: got %0d want 1", ndone); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nwin = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, k == 0, 8'(k));
            n_total++; if ({obs_valid, obs_done} !== {exp_valid, exp_done}) $display("FAIL rmid_flags k=%0d: got %b%b want %b%b", k, obs_valid, obs_done, exp_valid, exp_done); else n_pass++;
        end
        pix_valid = 1'b1; sof = 1'b0; pix_in = 8'd12;
        rst_n = 1'b0; #1;
        exp_win = '0; win_known = 1'b1; in_frame = 1'b0;
        n_total++; if ({obs_valid, obs_done} !== 2'b00 || obs_win !== exp_win) $display("FAIL rmid_zero: got %b%b %h want 00 %h", obs_valid, obs_done, obs_win, exp_win); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 13; k < 32; k++) begin
            step(1'b1, 1'b0, 8'(k));
            n_total++; if ({obs_valid, obs_done} !== {exp_valid, exp_done} || obs_win !== exp_win) $display("FAIL rmid_after k=%0d: got %b%b %h want %b%b %h", k, obs_valid, obs_done, obs_win, exp_valid, exp_done, exp_win); else n_pass++;
            nwin += int'(obs_valid);
        end
        n_total++; if (nwin != 0) $display("FAIL rmid_count: got %0d want 0", nwin); else n_pass++;
    endtask

    task automatic test_random();
        int  nwin = 0, mwin = 0, ndone = 0, complete = 0, n, stop, k;
        logic v, s;
        sel = 1'b1; mw = 13; mh = 7; in_frame = 1'b0; win_known = 1'b0;
        n = mw * mh;
        for (int f = 0; f < 12; f++) begin
            stop = (f % 4 == 3) ? int'($urandom_range(1, n - 1)) : n;
            if (stop == n) complete++;
            k = 0;
            while (k < stop) begin
                v = ($urandom_range(0, 2) != 0);
                s = v ? (k == 0) : 1'($urandom_range(0, 1));
                step(v, s, 8'($urandom));
                if (v) k++;
                n_total++; if ({obs_valid, obs_done} !== {exp_valid, exp_done}) $display("FAIL rand_flags f=%0d k=%0d: got %b%b want %b%b", f, k, obs_valid, obs_done, exp_valid, exp_done); else n_pass++;
                if (win_known) begin
                    n_total++; if (obs_win !== exp_win) $display("FAIL rand_win f=%0d k=%0d: got %h want %h", f, k, obs_win, exp_win); else n_pass++;
                end
                nwin += int'(obs_valid); mwin += int'(exp_valid); ndone += int'(obs_done);
            end
        end
        n_total++; if (nwin != mwin) $display("FAIL rand_windows: got %0d want %0d", nwin, mwin); else n_pass++;
        n_total++; if (ndone != complete) $display("FAIL rand_done: got %0d want %0d", ndone, complete); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                first_win[i][j] = 8'(i*4 + j);
        test_reset();
        test_ramp();
        test_gaps();
        test_restart();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
